// File: rtl/stim_sweep_gen.sv
// ============================================================================
// Module      : stim_sweep_gen
// Description : Clocked exhaustive stimulus sweep for small combinational
//               blocks. Walks vectors 0..2^WIDTH-1, holds each one for HOLD
//               cycles, samples the single-bit response once per vector and
//               builds the captured truth table, a ones count and an
//               optional MISR signature.
// Options     : define SIG_MISR_EN to build the 16-bit MISR (poly 0x1021,
//               seed 16'hFFFF); otherwise signature is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stim_sweep_gen #(
   parameter int WIDTH = 5,   // DUT inputs, 1..8
   parameter int HOLD  = 10   // cycles per vector, >= 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    abort,
   input  logic                    resp_in,
   output logic [WIDTH-1:0]        vec_out,
   output logic                    vec_valid,
   output logic                    busy,
   output logic                    done,
   output logic [(1<<WIDTH)-1:0]   resp_map,
   output logic [WIDTH:0]          ones_count,
   output logic [15:0]             signature
);

   localparam int                  c_NVEC      = 1 << WIDTH;
   // Hold counter needs at least one bit even when HOLD == 1
   localparam int                  c_HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [WIDTH-1:0]    c_LAST_VEC  = {WIDTH{1'b1}};
   localparam logic [c_HW-1:0]     c_LAST_HOLD = c_HW'(HOLD - 1);
   localparam logic [15:0]         c_MISR_SEED = 16'hFFFF;
   localparam logic [15:0]         c_MISR_POLY = 16'h1021;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t              r_state;
   logic [WIDTH-1:0]    r_vec;
   logic [c_HW-1:0]     r_hold;
   logic                r_valid;
   logic                r_busy;
   logic                r_done;
   logic [c_NVEC-1:0]   r_map;
   logic [WIDTH:0]      r_ones;

   logic                w_start;
   logic                w_abort;
   logic                w_sample;

   // start is honoured only outside a sweep; it also wins over abort there
   assign w_start  = start && (r_state != ST_DRIVE);
   assign w_abort  = abort && (r_state == ST_DRIVE);
   // abort suppresses a coincident sample edge
   assign w_sample = (r_state == ST_DRIVE) && !abort && (r_hold == c_LAST_HOLD);

   // Sweep sequencer: vector stepping, hold timing, result capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_vec   <= '0;
         r_hold  <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_map   <= '0;
         r_ones  <= '0;
      end else if (w_start) begin
         r_state <= ST_DRIVE;
         r_vec   <= '0;
         r_hold  <= '0;
         r_valid <= 1'b1;
         r_busy  <= 1'b1;
         r_done  <= 1'b0;
         r_map   <= '0;
         r_ones  <= '0;
      end else if (w_abort) begin
         // partial results are deliberately kept for inspection
         r_state <= ST_IDLE;
         r_vec   <= '0;
         r_hold  <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (r_state == ST_DRIVE) begin
         if (!w_sample) begin
            r_hold <= r_hold + 1'b1;
         end else begin
            r_map[r_vec] <= resp_in;
            r_ones       <= r_ones + {{WIDTH{1'b0}}, resp_in};
            if (r_vec == c_LAST_VEC) begin
               // vec_out keeps the last vector while results are frozen
               r_state <= ST_DONE;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end else begin
               r_vec  <= r_vec + 1'b1;
               r_hold <= '0;
            end
         end
      end
   end

   assign vec_out    = r_vec;
   assign vec_valid  = r_valid;
   assign busy       = r_busy;
   assign done       = r_done;
   assign resp_map   = r_map;
   assign ones_count = r_ones;

`ifdef SIG_MISR_EN
   logic [15:0] r_sig;
   logic        w_fb;

   assign w_fb = r_sig[15] ^ resp_in;

   // Serial MISR over the sampled responses, reseeded on every start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sig <= c_MISR_SEED;
      end else if (w_start) begin
         r_sig <= c_MISR_SEED;
      end else if (w_sample) begin
         r_sig <= {r_sig[14:0], 1'b0} ^ (w_fb ? c_MISR_POLY : 16'h0000);
      end
   end

   assign signature = r_sig;
`else
   assign signature = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stim_sweep_gen.sv
// ============================================================================
// Module      : tb_stim_sweep_gen
// Description : Directed self-checking bench for stim_sweep_gen. Two
//               instances (HOLD=10 and HOLD=1, WIDTH=5) with combinational
//               response functions driven from their own vec_out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stim_sweep_gen;

   logic        clk;
   logic        rst;

   // Instance A: HOLD = 10
   logic        start_a, abort_a, resp_a;
   logic [1:0]  mode_a;   // 0: zero, 1: AND, 2: XOR, 3: OR
   logic [4:0]  vec_a;
   logic        valid_a, busy_a, done_a;
   logic [31:0] map_a;
   logic [5:0]  ones_a;
   logic [15:0] sig_a;

   // Instance B: HOLD = 1, XOR parity response
   logic        start_b, abort_b, resp_b;
   logic [4:0]  vec_b;
   logic        valid_b, busy_b, done_b;
   logic [31:0] map_b;
   logic [5:0]  ones_b;
   logic [15:0] sig_b;

   int          errors = 0;
   int          checks = 0;

   assign resp_a = (mode_a == 2'd1) ? (&vec_a) :
                   (mode_a == 2'd2) ? (^vec_a) :
                   (mode_a == 2'd3) ? (|vec_a) : 1'b0;
   assign resp_b = ^vec_b;

   stim_sweep_gen #(.WIDTH(5), .HOLD(10)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .resp_in(resp_a),
      .vec_out(vec_a), .vec_valid(valid_a), .busy(busy_a), .done(done_a),
      .resp_map(map_a), .ones_count(ones_a), .signature(sig_a)
   );

   stim_sweep_gen #(.WIDTH(5), .HOLD(1)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .resp_in(resp_b),
      .vec_out(vec_b), .vec_valid(valid_b), .busy(busy_b), .done(done_b),
      .resp_map(map_b), .ones_count(ones_b), .signature(sig_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 ns past the edge
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Expected signature after the first n samples of response map m
   function automatic logic [15:0] sig_exp(input logic [31:0] m, input int n);
      logic [15:0] s;
      logic        fb;
      s = 16'hFFFF;
      for (int k = 0; k < n; k++) begin
         fb = s[15] ^ m[k];
         s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
`ifndef SIG_MISR_EN
      s = 16'h0000;
`endif
      return s;
   endfunction

   // Truth table of 5-input XOR parity: bit k = ^k
   function automatic logic [31:0] parity_map();
      logic [31:0] m;
      logic [4:0]  kv;
      m = '0;
      for (int k = 0; k < 32; k++) begin
         kv   = 5'(k);
         m[k] = ^kv;
      end
      return m;
   endfunction

   initial begin
      logic [31:0] pmap;
      pmap    = parity_map();   // equals 32'h9669_6996
      rst     = 1'b1;
      start_a = 1'b0; abort_a = 1'b0; mode_a = 2'd0;
      start_b = 1'b0; abort_b = 1'b0;

      // ---- reset state
      #12;
      check("rst_vec",   64'(vec_a),   64'd0);
      check("rst_valid", 64'(valid_a), 64'd0);
      check("rst_busy",  64'(busy_a),  64'd0);
      check("rst_done",  64'(done_a),  64'd0);
      check("rst_map",   64'(map_a),   64'd0);
      check("rst_ones",  64'(ones_a),  64'd0);
      check("rst_sig",   64'(sig_a),   64'(sig_exp(32'h0, 0)));
      @(negedge clk) rst = 1'b0;
      tick(1);

      // ---- AND sweep, HOLD=10
      mode_a = 2'd1; start_a = 1'b1; tick(1); start_a = 1'b0;   // E0
      check("and_e0_vec",   64'(vec_a),   64'd0);
      check("and_e0_valid", 64'(valid_a), 64'd1);
      check("and_e0_busy",  64'(busy_a),  64'd1);
      check("and_e0_done",  64'(done_a),  64'd0);
      tick(9);
      check("and_hold_vec", 64'(vec_a), 64'd0);
      tick(1);
      check("and_step_vec", 64'(vec_a), 64'd1);
      tick(309);                                                  // E0+319
      check("and_319_done", 64'(done_a), 64'd0);
      check("and_319_vec",  64'(vec_a),  64'd31);
      check("and_319_busy", 64'(busy_a), 64'd1);
      tick(1);                                                    // E0+320
      check("and_done",     64'(done_a),  64'd1);
      check("and_busy",     64'(busy_a),  64'd0);
      check("and_valid",    64'(valid_a), 64'd0);
      check("and_vec_hold", 64'(vec_a),   64'd31);
      check("and_map",      64'(map_a),   64'h8000_0000);
      check("and_ones",     64'(ones_a),  64'd1);
      check("and_sig",      64'(sig_a),   64'(sig_exp(32'h8000_0000, 32)));
      tick(5);
      check("and_sticky",   64'(done_a), 64'd1);
      check("and_frozen",   64'(map_a),  64'h8000_0000);

      // ---- restart from DONE with zero response; mid-sweep start ignored
      mode_a = 2'd0; start_a = 1'b1; tick(1); start_a = 1'b0;    // E0
      check("rs_done_clr", 64'(done_a), 64'd0);
      check("rs_map_clr",  64'(map_a),  64'd0);
      check("rs_ones_clr", 64'(ones_a), 64'd0);
      check("rs_busy",     64'(busy_a), 64'd1);
      tick(36); start_a = 1'b1; tick(1); start_a = 1'b0;         // E0+37
      check("rs_mid_vec",  64'(vec_a), 64'd3);
      tick(282);                                                  // E0+319
      check("rs_319_done", 64'(done_a), 64'd0);
      tick(1);
      check("rs_done",     64'(done_a), 64'd1);
      check("rs_map",      64'(map_a),  64'd0);
      check("rs_ones",     64'(ones_a), 64'd0);
      check("rs_sig",      64'(sig_a),  64'(sig_exp(32'h0, 32)));

      // ---- abort at E0+55 with OR response
      mode_a = 2'd3; start_a = 1'b1; tick(1); start_a = 1'b0;    // E0
      tick(54); abort_a = 1'b1; tick(1); abort_a = 1'b0;         // E0+55
      check("ab_busy",  64'(busy_a),  64'd0);
      check("ab_valid", 64'(valid_a), 64'd0);
      check("ab_vec",   64'(vec_a),   64'd0);
      check("ab_done",  64'(done_a),  64'd0);
      check("ab_map",   64'(map_a),   64'h1E);
      check("ab_ones",  64'(ones_a),  64'd4);
      check("ab_sig",   64'(sig_a),   64'(sig_exp(32'h1E, 5)));
      tick(3);
      check("ab_idle_busy", 64'(busy_a), 64'd0);
      check("ab_idle_map",  64'(map_a),  64'h1E);

      // ---- start and abort together in IDLE: start wins
      start_a = 1'b1; abort_a = 1'b1; tick(1); start_a = 1'b0;
      check("sa_busy", 64'(busy_a), 64'd1);
      check("sa_map",  64'(map_a),  64'd0);
      tick(1); abort_a = 1'b0;
      check("sa_abort_busy", 64'(busy_a), 64'd0);

      // ---- async reset mid-sweep, between edges
      mode_a = 2'd3; start_a = 1'b1; tick(1); start_a = 1'b0;    // E0
      tick(100);                                                  // E0+100
      check("ar_pre_map",  64'(map_a),  64'h3FE);
      check("ar_pre_ones", 64'(ones_a), 64'd9);
      #2 rst = 1'b1;
      #1;
      check("ar_vec",   64'(vec_a),   64'd0);
      check("ar_valid", 64'(valid_a), 64'd0);
      check("ar_busy",  64'(busy_a),  64'd0);
      check("ar_done",  64'(done_a),  64'd0);
      check("ar_map",   64'(map_a),   64'd0);
      check("ar_ones",  64'(ones_a),  64'd0);
      check("ar_sig",   64'(sig_a),   64'(sig_exp(32'h0, 0)));
      @(negedge clk) rst = 1'b0;
      tick(1);
      start_a = 1'b1; tick(1); start_a = 1'b0;
      tick(320);
      check("ar_full_done", 64'(done_a), 64'd1);
      check("ar_full_map",  64'(map_a),  64'hFFFF_FFFE);
      check("ar_full_ones", 64'(ones_a), 64'd31);
      check("ar_full_sig",  64'(sig_a),  64'(sig_exp(32'hFFFF_FFFE, 32)));

      // ---- XOR parity sweep, HOLD=1
      check("b_idle_sig", 64'(sig_b), 64'(sig_exp(32'h0, 0)));
      start_b = 1'b1; tick(1); start_b = 1'b0;                   // E0
      check("b_e0_vec",   64'(vec_b),   64'd0);
      check("b_e0_valid", 64'(valid_b), 64'd1);
      tick(1);
      check("b_e1_vec",   64'(vec_b), 64'd1);
      tick(30);                                                   // E0+31
      check("b_31_done",  64'(done_b), 64'd0);
      check("b_31_vec",   64'(vec_b),  64'd31);
      tick(1);                                                    // E0+32
      check("b_done",     64'(done_b), 64'd1);
      check("b_map",      64'(map_b),  64'(pmap));
      check("b_ones",     64'(ones_b), 64'd16);
      check("b_sig",      64'(sig_b),  64'(sig_exp(pmap, 32)));
      abort_b = 1'b1; tick(1); abort_b = 1'b0;
      check("b_abort_in_done", 64'(done_b), 64'd1);
      check("b_abort_vec",     64'(vec_b),  64'd31);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
